// File: rtl/tx_app2hip_arbiter.sv
// Round-robin arbiter sharing the 256-bit Avalon-ST TX port of the PCIe HIP.
// Owner stream is registered once; sticky flags report protocol and hold errors.
module tx_app2hip_arbiter #(
  parameter int NREQ     = 3,
  parameter int IDX_W    = $clog2(NREQ),
  parameter int HOLD_MAX = 1024
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [NREQ-1:0]       iREQ,
  output logic [NREQ-1:0]       oGNT,
  input  logic [NREQ-1:0]       iTX_SOP,
  input  logic [NREQ-1:0]       iTX_EOP,
  input  logic [NREQ-1:0]       iTX_VALID,
  input  logic [2*NREQ-1:0]     iTX_EMPTY,
  input  logic [256*NREQ-1:0]   iTX_DATA,
  input  logic                  iHIP_READY,
  output logic                  oTX_SOP,
  output logic                  oTX_EOP,
  output logic                  oTX_VALID,
  output logic [1:0]            oTX_EMPTY,
  output logic [255:0]          oTX_DATA,
  output logic [IDX_W-1:0]      oOWNER,
  output logic                  oBUSY,
  input  logic                  iERR_CLR,
  output logic                  oERR_PROTO,
  output logic                  oERR_TIMEOUT
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] IDLE_ST  = 2'd0;
  localparam logic [1:0] GRANT_ST = 2'd1;
  localparam logic [1:0] GAP_ST   = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic [CNT_W-1:0] holdCnt;
  logic             protoEv;
  logic             timeoutEv;
  logic             drain;

  // Search upward from ptr+1 so the last winner has lowest priority
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((32'(ptr) + 32'(i)) % NREQ);
      if (!found && iREQ[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign oBUSY = (state == GRANT_ST);
  assign drain = (state == GRANT_ST) || (state == GAP_ST);

  assign protoEv = (state == GRANT_ST) &&
                   |(iTX_VALID & ~oGNT);
  assign timeoutEv = (state == GRANT_ST) &&
                     (holdCnt == CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE_ST;
      oGNT    <= '0;
      oOWNER  <= '0;
      ptr     <= '0;
      holdCnt <= '0;
    end else begin
      unique case (state)
        IDLE_ST: begin
          if (found && iHIP_READY) begin
            state   <= GRANT_ST;
            oGNT    <= NREQ'(1) << winner;
            oOWNER  <= winner;
            ptr     <= winner;
            holdCnt <= '0;
          end
        end
        GRANT_ST: begin
          if (holdCnt != CNT_W'(HOLD_MAX))
            holdCnt <= holdCnt + 1'b1;
          if (!iREQ[oOWNER]) begin
            oGNT    <= '0;
            state   <= GAP_ST;
            holdCnt <= '0;
          end
        end
        GAP_ST:  state <= IDLE_ST;
        default: state <= IDLE_ST;
      endcase
    end
  end

  // Previous owner keeps driving through the gap so its last beat drains
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oTX_SOP   <= 1'b0;
      oTX_EOP   <= 1'b0;
      oTX_VALID <= 1'b0;
      oTX_EMPTY <= '0;
      oTX_DATA  <= '0;
    end else if (drain) begin
      oTX_SOP   <= iTX_SOP[oOWNER];
      oTX_EOP   <= iTX_EOP[oOWNER];
      oTX_VALID <= iTX_VALID[oOWNER];
      oTX_EMPTY <= iTX_EMPTY[2*oOWNER +: 2];
      oTX_DATA  <= iTX_DATA[256*oOWNER +: 256];
    end else begin
      oTX_SOP   <= 1'b0;
      oTX_EOP   <= 1'b0;
      oTX_VALID <= 1'b0;
    end
  end

  // Set wins over a coincident clear
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oERR_PROTO   <= 1'b0;
      oERR_TIMEOUT <= 1'b0;
    end else begin
      oERR_PROTO   <= (oERR_PROTO & ~iERR_CLR) | protoEv;
      oERR_TIMEOUT <= (oERR_TIMEOUT & ~iERR_CLR) | timeoutEv;
    end
  end

endmodule

// File: tb/tb_tx_app2hip_arbiter.sv
// Directed bench for tx_app2hip_arbiter with NREQ=3, HOLD_MAX=16.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_tx_app2hip_arbiter;

  localparam int NREQ = 3;
  localparam int IDX_W = 2;

  logic               iCLK = 1'b0;
  logic               iRST_N;
  logic [NREQ-1:0]    iREQ;
  logic [NREQ-1:0]    oGNT;
  logic [NREQ-1:0]    iTX_SOP;
  logic [NREQ-1:0]    iTX_EOP;
  logic [NREQ-1:0]    iTX_VALID;
  logic [2*NREQ-1:0]  iTX_EMPTY;
  logic [256*NREQ-1:0] iTX_DATA;
  logic               iHIP_READY;
  logic               oTX_SOP;
  logic               oTX_EOP;
  logic               oTX_VALID;
  logic [1:0]         oTX_EMPTY;
  logic [255:0]       oTX_DATA;
  logic [IDX_W-1:0]   oOWNER;
  logic               oBUSY;
  logic               iERR_CLR;
  logic               oERR_PROTO;
  logic               oERR_TIMEOUT;

  int nChk = 0;
  int nPass = 0;

  tx_app2hip_arbiter #(
    .NREQ(NREQ),
    .IDX_W(IDX_W),
    .HOLD_MAX(16)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iREQ(iREQ),
    .oGNT(oGNT),
    .iTX_SOP(iTX_SOP),
    .iTX_EOP(iTX_EOP),
    .iTX_VALID(iTX_VALID),
    .iTX_EMPTY(iTX_EMPTY),
    .iTX_DATA(iTX_DATA),
    .iHIP_READY(iHIP_READY),
    .oTX_SOP(oTX_SOP),
    .oTX_EOP(oTX_EOP),
    .oTX_VALID(oTX_VALID),
    .oTX_EMPTY(oTX_EMPTY),
    .oTX_DATA(oTX_DATA),
    .oOWNER(oOWNER),
    .oBUSY(oBUSY),
    .iERR_CLR(iERR_CLR),
    .oERR_PROTO(oERR_PROTO),
    .oERR_TIMEOUT(oERR_TIMEOUT)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic setBeat(input int idx, input logic sop,
                         input logic eop, input logic vld,
                         input logic [1:0] emp,
                         input logic [255:0] dat);
    iTX_SOP[idx]            = sop;
    iTX_EOP[idx]            = eop;
    iTX_VALID[idx]          = vld;
    iTX_EMPTY[2*idx +: 2]   = emp;
    iTX_DATA[256*idx +: 256] = dat;
  endtask

  function automatic logic [255:0] beatData(input int r, input int b);
    return {8{32'hC0DE_0000 + 32'(r * 256 + b)}};
  endfunction

  logic [NREQ-1:0] rrExp [5];
  logic [255:0] keep;

  initial begin
    rrExp[0] = 3'b010;
    rrExp[1] = 3'b100;
    rrExp[2] = 3'b001;
    rrExp[3] = 3'b010;
    rrExp[4] = 3'b100;

    iRST_N = 1'b0;
    iREQ = '0;
    iTX_SOP = '0;
    iTX_EOP = '0;
    iTX_VALID = '0;
    iTX_EMPTY = '0;
    iTX_DATA = '0;
    iHIP_READY = 1'b0;
    iERR_CLR = 1'b0;
    tick();
    tick();
    chk("rst_gnt", oGNT, 0);
    chk("rst_valid", oTX_VALID, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_owner", oOWNER, 0);
    chk("rst_errs", {oERR_PROTO, oERR_TIMEOUT}, 0);
    iRST_N = 1'b1;
    tick();

    // single requester, 9-beat packet
    iREQ = 3'b001;
    iHIP_READY = 1'b1;
    tick();
    chk("single_gnt", oGNT, 3'b001);
    chk("single_busy", oBUSY, 1);
    chk("single_owner", oOWNER, 0);
    for (int b = 0; b < 9; b++) begin
      setBeat(0, b == 0, b == 8, 1'b1,
              (b == 8) ? 2'd1 : 2'd0, beatData(0, b));
      tick();
      chk("beat_data", oTX_DATA, beatData(0, b));
      chk("beat_ctl", {oTX_SOP, oTX_EOP, oTX_VALID, oTX_EMPTY},
          {b == 0, b == 8, 1'b1, (b == 8) ? 2'd1 : 2'd0});
    end
    setBeat(0, 0, 0, 0, 0, '0);
    iREQ = 3'b000;
    tick();
    chk("drop_gnt", oGNT, 0);
    chk("drop_busy", oBUSY, 0);
    iREQ = 3'b001;
    tick();
    chk("gap_gnt", oGNT, 0);
    tick();
    chk("regrant", oGNT, 3'b001);
    chk("regrant_valid", oTX_VALID, 0);
    iREQ = 3'b000;
    tick();
    tick();

    // all three requesting, 5 cycles each
    iREQ = 3'b111;
    tick();
    chk("rr0", oGNT, rrExp[0]);
    for (int k = 0; k < 4; k++) begin
      repeat (4) tick();
      chk("rr_hold", oGNT, rrExp[k]);
      iREQ = iREQ & ~rrExp[k];
      tick();
      chk("rr_rel", oGNT, 0);
      iREQ = 3'b111;
      tick();
      chk("rr_gap", oGNT, 0);
      tick();
      chk("rr_next", oGNT, rrExp[k+1]);
    end
    iREQ = 3'b000;
    tick();
    tick();
    tick();

    // HIP not ready holds off the grant
    iHIP_READY = 1'b0;
    iREQ = 3'b010;
    repeat (10) tick();
    chk("nrdy_gnt", oGNT, 0);
    chk("nrdy_busy", oBUSY, 0);
    iHIP_READY = 1'b1;
    tick();
    chk("rdy_gnt", oGNT, 3'b010);
    iREQ = 3'b000;
    tick();
    tick();
    tick();

    // non-owner valid sets the protocol flag
    iREQ = 3'b001;
    tick();
    chk("proto_gnt", oGNT, 3'b001);
    keep = beatData(0, 7);
    setBeat(0, 1, 0, 1, 0, keep);
    tick();
    chk("proto_pre", oERR_PROTO, 0);
    setBeat(2, 1, 1, 1, 2'd3, beatData(2, 9));
    tick();
    chk("proto_set", oERR_PROTO, 1);
    chk("proto_data", oTX_DATA, keep);
    setBeat(2, 0, 0, 0, 0, '0);
    tick();
    chk("proto_sticky", oERR_PROTO, 1);
    iERR_CLR = 1'b1;
    tick();
    iERR_CLR = 1'b0;
    chk("proto_clr", oERR_PROTO, 0);
    iERR_CLR = 1'b1;
    setBeat(1, 0, 0, 1, 0, '0);
    tick();
    iERR_CLR = 1'b0;
    setBeat(1, 0, 0, 0, 0, '0);
    chk("proto_setwins", oERR_PROTO, 1);
    iERR_CLR = 1'b1;
    tick();
    iERR_CLR = 1'b0;
    chk("proto_clr2", oERR_PROTO, 0);
    setBeat(0, 0, 0, 0, 0, '0);
    iREQ = 3'b000;
    tick();
    tick();
    tick();

    // grant held past HOLD_MAX
    iREQ = 3'b010;
    tick();
    chk("to_gnt", oGNT, 3'b010);
    repeat (15) tick();
    chk("to_15", oERR_TIMEOUT, 0);
    tick();
    chk("to_16", oERR_TIMEOUT, 1);
    chk("to_gnt16", oGNT, 3'b010);
    repeat (24) tick();
    chk("to_40", oGNT, 3'b010);
    chk("to_sticky", oERR_TIMEOUT, 1);
    iERR_CLR = 1'b1;
    tick();
    iERR_CLR = 1'b0;
    chk("to_clr", oERR_TIMEOUT, 0);
    iREQ = 3'b000;
    tick();
    tick();
    tick();

    // asynchronous reset mid-packet
    iREQ = 3'b111;
    tick();
    chk("mid_gnt", oGNT, 3'b100);
    for (int b = 0; b < 5; b++) begin
      setBeat(2, b == 0, 0, 1, 0, beatData(2, b));
      tick();
    end
    chk("mid_valid", oTX_VALID, 1);
    iRST_N = 1'b0;
    #1;
    chk("async_gnt", oGNT, 0);
    chk("async_valid", oTX_VALID, 0);
    chk("async_busy", oBUSY, 0);
    setBeat(2, 0, 0, 0, 0, '0);
    tick();
    iRST_N = 1'b1;
    tick();
    chk("post_rst_gnt", oGNT, 3'b010);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/tx_app2hip_arbiter.md
Name: tx_app2hip_arbiter

Overview:
- Shares the single 256-bit Avalon-ST TX interface into the PCIe hard IP between NREQ TLP sources: DMA write engine, completion engine and MSI/interrupt engine.
- Runs a round-robin request/grant handshake; a grant is held until the owner drops its request.
- Muxes the owner's TX stream through one register stage to the HIP.
- Raises sticky error flags for protocol violations and for a grant held too long.

Parameters:
- NREQ, 3, number of requesters (2..8).
- IDX_W, $clog2(NREQ), width of the owner index.
- HOLD_MAX, 1024, maximum number of cycles a single grant may be held before the timeout error flag sets.

Ports:
- iCLK  in  1  clock; all logic is on its rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iREQ  in  NREQ  per-requester request; held high for the whole transfer.
- oGNT  out  NREQ  one-hot grant.
- iTX_SOP  in  NREQ  per-requester start of packet.
- iTX_EOP  in  NREQ  per-requester end of packet.
- iTX_VALID  in  NREQ  per-requester data valid.
- iTX_EMPTY  in  NREQ x 2  per-requester empty code.
- iTX_DATA  in  NREQ x 256  per-requester data.
- iHIP_READY  in  1  HIP TX ready; sampled only when a grant is about to be issued.
- oTX_SOP  out  1  registered stream to the HIP.
- oTX_EOP  out  1  registered stream to the HIP.
- oTX_VALID  out  1  registered stream to the HIP.
- oTX_EMPTY  out  2  registered stream to the HIP.
- oTX_DATA  out  256  registered stream to the HIP.
- oOWNER  out  IDX_W  index of the current or most recent grantee.
- oBUSY  out  1  high when the FSM is in GRANT_ST.
- iERR_CLR  in  1  synchronous clear of both sticky error flags.
- oERR_PROTO  out  1  sticky: valid asserted by a requester that does not hold the grant.
- oERR_TIMEOUT  out  1  sticky: a grant was held for HOLD_MAX cycles.

Behaviour:
- Reset (iRST_N low, asynchronous): state IDLE_ST, all outputs 0, round-robin pointer 0, hold counter 0. A reset mid-packet truncates the packet; oTX_VALID drops in the same instant.
- FSM states: IDLE_ST, GRANT_ST, GAP_ST.
- IDLE_ST: if any iREQ bit is set and iHIP_READY is high, select the winner and go to GRANT_ST.
  - Winner = first set iREQ bit searching upward from pointer+1, wrapping modulo NREQ.
  - On the same edge: oGNT[winner] <= 1, oOWNER <= winner, pointer <= winner.
  - If iHIP_READY is low, stay in IDLE_ST and issue no grant.
- GRANT_ST:
  - oGNT is stable.
  - The output register loads the owner's SOP, EOP, VALID, EMPTY and DATA every cycle, so the owner's cycle-N stream appears on oTX_* at cycle N+1.
  - Non-owner stream inputs are ignored. Any such input with iTX_VALID high sets oERR_PROTO.
  - The hold counter increments each cycle. When it reaches HOLD_MAX-1, oERR_TIMEOUT sets; the grant is NOT revoked.
  - When iREQ[owner] is 0: clear oGNT, go to GAP_ST, reset the hold counter.
- GAP_ST:
  - Exactly one cycle with no grant. The output register still loads the previous owner's stream, so its final beat drains.
  - Then go to IDLE_ST.
  - Minimum spacing from one owner's request drop to the next grant is therefore 2 cycles.
- oTX_VALID, oTX_SOP and oTX_EOP are 0 in IDLE_ST, and 0 from the second cycle after GAP_ST onward.
- Simultaneous requests: resolved strictly by the round-robin pointer. A requester that has just been served has the lowest priority on the next arbitration.
- A request raised and dropped while another requester owns the grant is not remembered.
- A single requester re-requesting after release gets the grant again; the minimum gap still applies.
- iERR_CLR: clears both flags on the next edge. If the clear coincides with a new error event, the flag sets (set wins).
- oBUSY = (state == GRANT_ST).

Test Plan:
- Single requester: iREQ=3'b001 with iHIP_READY=1 -> oGNT=3'b001 one cycle later. Drive 9 beats, SOP on beat 0 and EOP on beat 8 with empty code 1 -> oTX_* match each input beat delayed by exactly 1 cycle. Drop iREQ -> oGNT=0 on the next edge and a 1-cycle gap follows.
- All three requesting continuously, each releasing after 5 cycles -> grant order 1, 2, 0, 1, 2. Each grant is 2 cycles after the previous release.
- iREQ=3'b010 held while iHIP_READY=0 for 10 cycles -> oGNT stays 0. Raise iHIP_READY -> oGNT=3'b010 on the next edge.
- Owner 0 streaming; requester 2 pulses iTX_VALID for one cycle -> oERR_PROTO=1 and stays set, oTX_DATA is unaffected. Pulse iERR_CLR -> flag returns to 0.
- With HOLD_MAX=16, hold iREQ[1] for 40 cycles -> oERR_TIMEOUT sets on the 16th held cycle and oGNT[1] stays 1 throughout.
- Assert iRST_N=0 mid-packet at beat 4 -> oGNT, oTX_VALID and oBUSY go to 0 immediately. After release, the first grant goes to requester 1 when all requesters are active, because the pointer is 0.
